// File: rtl/systolic_ws_ctrl.sv
// Sequencer for the weight-stationary systolic GEMM datapath: one weight-load strobe,
// diagonally skewed source reads, de-skewed result writes and a completion pulse.
module systolic_ws_ctrl #(
   parameter int DATA_WIDTH     = 32,
   parameter int ROW_NUM        = 8,
   parameter int COL_NUM        = 8,
   parameter int LENGTH         = 8,
   parameter int DPATH_LAT      = LENGTH,
   parameter int ROW_ADDR_WIDTH = $clog2(ROW_NUM)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      val_in,
   output logic                      rdy_in,
   input  logic [ROW_ADDR_WIDTH:0]   num_rows,
   output logic                      wt_ld,
   output logic                      row_rd_en  [0:LENGTH-1],
   output logic [ROW_ADDR_WIDTH-1:0] row_rdaddr [0:LENGTH-1],
   output logic                      row_wr_en  [0:COL_NUM-1],
   output logic [ROW_ADDR_WIDTH-1:0] row_wraddr [0:COL_NUM-1],
   output logic                      busy,
   output logic                      done
);
   localparam int AW = ROW_ADDR_WIDTH;
   localparam int CH = DPATH_LAT + COL_NUM;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_FEED  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [AW:0] N_MAX = (AW+1)'(ROW_NUM);
   localparam logic [AW:0] N_ONE = (AW+1)'(1);

   if (DATA_WIDTH < 1 || ROW_NUM < 2 || COL_NUM < 1 || LENGTH < 1 || DPATH_LAT < 0) begin : g_bad_params
      $error("systolic_ws_ctrl: unsupported parameter set");
   end

   logic [2:0]    state_q, state_d;
   logic [AW:0]   n_q, n_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          rdy_q, rdy_d;
   logic          busy_q, busy_d;
   logic          wt_ld_q, wt_ld_d;
   logic          done_q, done_d;
   logic          iss_en_s;
   logic [AW-1:0] iss_addr_s;
   logic          last_wr_s;

   logic          rd_en_q   [LENGTH];
   logic [AW-1:0] rd_addr_q [LENGTH];
   // Write delay line: stage i trails lane 0 by i+1 cycles; column j taps stage DPATH_LAT+j.
   logic          ch_en_q   [CH];
   logic [AW-1:0] ch_addr_q [CH];

   assign last_wr_s = ch_en_q[CH-1] && ({1'b0, ch_addr_q[CH-1]} == (n_q - N_ONE));
   assign busy_d    = (state_d != S_IDLE);

   // Job FSM and lane-0 issue counter
   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      cnt_d      = cnt_q;
      rdy_d      = 1'b0;
      wt_ld_d    = 1'b0;
      done_d     = 1'b0;
      iss_en_s   = 1'b0;
      iss_addr_s = '0;
      case (state_q)
         S_IDLE: begin
            rdy_d = 1'b1;
            if (val_in) begin
               state_d = S_LOAD;
               rdy_d   = 1'b0;
               wt_ld_d = 1'b1;
               n_d     = (num_rows > N_MAX) ? N_MAX : num_rows;
               cnt_d   = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            if (n_q == '0) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               state_d  = S_FEED;
               iss_en_s = 1'b1;
               cnt_d    = N_ONE;
            end
         end
         S_FEED: begin
            if (cnt_q < n_q) begin
               iss_en_s   = 1'b1;
               iss_addr_s = cnt_q[AW-1:0];
               cnt_d      = cnt_q + N_ONE;
            end else begin
               cnt_d = cnt_q;
            end
            if ((cnt_q + N_ONE) >= n_q) begin
               state_d = S_DRAIN;
            end else begin
               state_d = S_FEED;
            end
         end
         S_DRAIN: begin
            if (last_wr_s) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            rdy_d   = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
            rdy_d   = 1'b1;
         end
      endcase
   end

   // Control state and registered status outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         cnt_q   <= '0;
         rdy_q   <= 1'b1;
         busy_q  <= 1'b0;
         wt_ld_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         cnt_q   <= cnt_d;
         rdy_q   <= rdy_d;
         busy_q  <= busy_d;
         wt_ld_q <= wt_ld_d;
         done_q  <= done_d;
      end
   end

   // Read skew chain and write delay chain; idle tokens carry address 0
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < LENGTH; k++) begin
            rd_en_q[k]   <= 1'b0;
            rd_addr_q[k] <= '0;
         end
         for (int i = 0; i < CH; i++) begin
            ch_en_q[i]   <= 1'b0;
            ch_addr_q[i] <= '0;
         end
      end else begin
         rd_en_q[0]   <= iss_en_s;
         rd_addr_q[0] <= iss_addr_s;
         for (int k = 1; k < LENGTH; k++) begin
            rd_en_q[k]   <= rd_en_q[k-1];
            rd_addr_q[k] <= rd_addr_q[k-1];
         end
         ch_en_q[0]   <= rd_en_q[0];
         ch_addr_q[0] <= rd_addr_q[0];
         for (int i = 1; i < CH; i++) begin
            ch_en_q[i]   <= ch_en_q[i-1];
            ch_addr_q[i] <= ch_addr_q[i-1];
         end
      end
   end

   assign rdy_in = rdy_q;
   assign busy   = busy_q;
   assign wt_ld  = wt_ld_q;
   assign done   = done_q;

   for (genvar k = 0; k < LENGTH; k++) begin : g_rd
      assign row_rd_en[k]  = rd_en_q[k];
      assign row_rdaddr[k] = rd_addr_q[k];
   end

   for (genvar j = 0; j < COL_NUM; j++) begin : g_wr
      assign row_wr_en[j]  = ch_en_q[DPATH_LAT+j];
      assign row_wraddr[j] = ch_addr_q[DPATH_LAT+j];
   end
endmodule
